xgmii_decoder: RTL and testbench

Receive-side 64b/66b decoder for the 10GBASE-R PCS. It sits between the descrambler and the XGMII receive interface to the MAC, and is the mirror of the transmit encoder. It accepts each 66-bit block as a 2-bit sync header plus two 32-bit words on consecutive valid cycles, validates the block type against a receive state machine, and emits the eight decoded lanes as two 32-bit XGMII words. Ordering is lanes 0-3 first, then lanes 4-7.

---
 rtl/xgmii_pkg.sv | 68 ++++++
 rtl/xgmii_ctrl_decode.sv | 31 +++
 rtl/xgmii_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_xgmii_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - XGMII characters, 10GBASE-R control codes, block types and rx state enum
// Shared definitions for the 64b/66b receive decoder.
package xgmii_pkg;

    // XGMII characters
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_LPI   = 8'h06;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;
    localparam logic [7:0] XGMII_SIG   = 8'h5C;
    localparam logic [7:0] XGMII_RES0  = 8'h1C;
    localparam logic [7:0] XGMII_RES1  = 8'h3C;
    localparam logic [7:0] XGMII_RES2  = 8'h7C;
    localparam logic [7:0] XGMII_RES3  = 8'hBC;
    localparam logic [7:0] XGMII_RES4  = 8'hDC;
    localparam logic [7:0] XGMII_RES5  = 8'hF7;

    // 7-bit 10GBASE-R control codes
    localparam logic [6:0] CTRL_IDLE  = 7'h00;
    localparam logic [6:0] CTRL_LPI   = 7'h06;
    localparam logic [6:0] CTRL_ERROR = 7'h1E;
    localparam logic [6:0] CTRL_RES0  = 7'h2D;
    localparam logic [6:0] CTRL_RES1  = 7'h33;
    localparam logic [6:0] CTRL_RES2  = 7'h4B;
    localparam logic [6:0] CTRL_RES3  = 7'h55;
    localparam logic [6:0] CTRL_RES4  = 7'h66;
    localparam logic [6:0] CTRL_RES5  = 7'h78;

    // Sync headers
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Block type field values
    localparam logic [7:0] BT_CTRL   = 8'h1E;
    localparam logic [7:0] BT_START0 = 8'h78;
    localparam logic [7:0] BT_START4 = 8'h33;
    localparam logic [7:0] BT_OS0    = 8'h4B;
    localparam logic [7:0] BT_TERM0  = 8'h87;
    localparam logic [7:0] BT_TERM1  = 8'h99;
    localparam logic [7:0] BT_TERM2  = 8'hAA;
    localparam logic [7:0] BT_TERM3  = 8'hB4;
    localparam logic [7:0] BT_TERM4  = 8'hCC;
    localparam logic [7:0] BT_TERM5  = 8'hD2;
    localparam logic [7:0] BT_TERM6  = 8'hE1;
    localparam logic [7:0] BT_TERM7  = 8'hFF;

    typedef enum logic {RX_C, RX_D} rx_state_t;

    // Classification of a received block as seen by the receive FSM
    typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_class_t;

    // Lane that carries the terminate character for a terminate block type
    function automatic logic [2:0] term_lane(input logic [7:0] blk_type);
        case (blk_type)
            BT_TERM1: term_lane = 3'd1;
            BT_TERM2: term_lane = 3'd2;
            BT_TERM3: term_lane = 3'd3;
            BT_TERM4: term_lane = 3'd4;
            BT_TERM5: term_lane = 3'd5;
            BT_TERM6: term_lane = 3'd6;
            BT_TERM7: term_lane = 3'd7;
            default:  term_lane = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/xgmii_ctrl_decode.sv
// rtl/xgmii_ctrl_decode.sv - 7-bit 10GBASE-R control code to XGMII character
// Ports:
//   i_code  7-bit control field of one lane
//   o_char  XGMII control character (FE for unknown codes)
//   o_err   high when i_code is not a known control code
module xgmii_ctrl_decode
    import xgmii_pkg::*;
(
    input  logic [6:0] i_code,
    output logic [7:0] o_char,
    output logic       o_err
);

    always_comb begin
        o_char = XGMII_ERROR;
        o_err  = 1'b0;
        case (i_code)
            CTRL_IDLE:  o_char = XGMII_IDLE;
            CTRL_LPI:   o_char = XGMII_LPI;
            CTRL_ERROR: o_char = XGMII_ERROR;
            CTRL_RES0:  o_char = XGMII_RES0;
            CTRL_RES1:  o_char = XGMII_RES1;
            CTRL_RES2:  o_char = XGMII_RES2;
            CTRL_RES3:  o_char = XGMII_RES3;
            CTRL_RES4:  o_char = XGMII_RES4;
            CTRL_RES5:  o_char = XGMII_RES5;
            default:    o_err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/xgmii_decoder.sv
// rtl/xgmii_decoder.sv - 10GBASE-R receive 64b/66b block decoder to 32-bit XGMII
// Optional feature macro: XGMII_DECODER_ERR_CNT_EN adds o_err_count.
// Ports:
//   i_clk, i_reset           clock, asynchronous active-high reset
//   i_rx_data/i_rx_hdr       encoded word and sync header (header on first word)
//   i_rx_valid               word valid
//   i_rx_hdr_valid           first word of a block (qualified by i_rx_valid)
//   o_xgmii_rxd/o_xgmii_rxc  decoded lanes 0-3 then lanes 4-7
//   o_xgmii_valid            output word valid
//   o_decode_err             one-cycle pulse per erroneous or dropped block
//   o_err_count              saturating error pulse count (macro only)
module xgmii_decoder
    import xgmii_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [HDR_WIDTH-1:0]  i_rx_hdr,
    input  logic                  i_rx_valid,
    input  logic                  i_rx_hdr_valid,
    output logic [DATA_WIDTH-1:0] o_xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] o_xgmii_rxc,
    output logic                  o_xgmii_valid,
    output logic                  o_decode_err
`ifdef XGMII_DECODER_ERR_CNT_EN
    ,
    output logic [15:0]           o_err_count
`endif
);

    logic        w0_pending;
    logic [31:0] w0_data;
    logic [1:0]  w0_hdr;
    logic        hi_pending;
    logic [31:0] hi_rxd;
    logic [3:0]  hi_rxc;

    rx_state_t   state_q, state_d;
    blk_class_t  blk_class;
    logic        blk_err;

    logic [63:0] blk;
    logic [7:0]  blk_byte [8];
    logic [7:0]  cf_char [8];
    logic [7:0]  lane_d [8];
    logic        lane_c [8];
    logic [2:0]  term_n;
    logic [31:0] lo_rxd_d, hi_rxd_d;
    logic [3:0]  lo_rxc_d, hi_rxc_d;

    wire hdr_word  = i_rx_valid & i_rx_hdr_valid;
    wire accept_w1 = i_rx_valid & ~i_rx_hdr_valid & w0_pending;
    wire drop_w0   = hdr_word & w0_pending;

    assign blk    = {i_rx_data, w0_data};
    assign term_n = term_lane(blk[7:0]);

    for (genvar n = 0; n < 8; n++) begin : g_lane
        logic [7:0] c_char;
        logic       c_err;

        assign blk_byte[n] = blk[8*n +: 8];

        xgmii_ctrl_decode u_ctrl_decode (
            .i_code (blk[7*n+8 +: 7]),
            .o_char (c_char),
            .o_err  (c_err)
        );

        // An unknown C code only corrupts its own lane, never the block.
        assign cf_char[n] = c_err ? XGMII_ERROR : c_char;
    end

    always_comb begin : decode
        blk_class = BLK_E;
        for (int k = 0; k < 8; k++) begin
            lane_d[k] = XGMII_ERROR;
            lane_c[k] = 1'b1;
        end
        if (w0_hdr == SYNC_DATA) begin
            blk_class = BLK_D;
            for (int k = 0; k < 8; k++) begin
                lane_d[k] = blk_byte[k];
                lane_c[k] = 1'b0;
            end
        end else if (w0_hdr == SYNC_CTRL) begin
            case (blk_byte[0])
                BT_CTRL: begin
                    blk_class = BLK_C;
                    for (int k = 0; k < 8; k++) lane_d[k] = cf_char[k];
                end
                BT_START0: begin
                    blk_class = BLK_S;
                    lane_d[0] = XGMII_START;
                    for (int k = 1; k < 8; k++) begin
                        lane_d[k] = blk_byte[k];
                        lane_c[k] = 1'b0;
                    end
                end
                BT_START4: begin
                    blk_class = BLK_S;
                    for (int k = 0; k < 4; k++) lane_d[k] = cf_char[k];
                    lane_d[4] = XGMII_START;
                    for (int k = 5; k < 8; k++) begin
                        lane_d[k] = blk_byte[k];
                        lane_c[k] = 1'b0;
                    end
                end
                BT_OS0: begin
                    if (blk[35:32] == 4'h0 || blk[35:32] == 4'hF) begin
                        blk_class = BLK_C;
                        lane_d[0] = (blk[35:32] == 4'h0) ? XGMII_SEQ : XGMII_SIG;
                        for (int k = 1; k < 4; k++) begin
                            lane_d[k] = blk_byte[k];
                            lane_c[k] = 1'b0;
                        end
                        for (int k = 4; k < 8; k++) lane_d[k] = cf_char[k];
                    end
                end
                BT_TERM0, BT_TERM1, BT_TERM2, BT_TERM3,
                BT_TERM4, BT_TERM5, BT_TERM6, BT_TERM7: begin
                    blk_class = BLK_T;
                    for (int k = 0; k < 8; k++) begin
                        if (k < int'(term_n)) begin
                            // Lane k comes from byte k+1; k+1 never wraps here.
                            lane_d[k] = blk_byte[3'(k + 1)];
                            lane_c[k] = 1'b0;
                        end else if (k == int'(term_n)) begin
                            lane_d[k] = XGMII_TERM;
                        end else begin
                            lane_d[k] = XGMII_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin : rx_fsm
        state_d = state_q;
        blk_err = 1'b0;
        if (accept_w1) begin
            case (state_q)
                RX_C: begin
                    case (blk_class)
                        BLK_C:   state_d = RX_C;
                        BLK_S:   state_d = RX_D;
                        default: begin blk_err = 1'b1; state_d = RX_C; end
                    endcase
                end
                default: begin
                    case (blk_class)
                        BLK_D:   state_d = RX_D;
                        BLK_T:   state_d = RX_C;
                        default: begin blk_err = 1'b1; state_d = RX_C; end
                    endcase
                end
            endcase
        end
    end

    always_comb begin : pack
        lo_rxd_d = {lane_d[3], lane_d[2], lane_d[1], lane_d[0]};
        hi_rxd_d = {lane_d[7], lane_d[6], lane_d[5], lane_d[4]};
        lo_rxc_d = {lane_c[3], lane_c[2], lane_c[1], lane_c[0]};
        hi_rxc_d = {lane_c[7], lane_c[6], lane_c[5], lane_c[4]};
        if (blk_err) begin
            lo_rxd_d = {4{XGMII_ERROR}};
            hi_rxd_d = {4{XGMII_ERROR}};
            lo_rxc_d = 4'hF;
            hi_rxc_d = 4'hF;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= RX_C;
        else         state_q <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            w0_pending    <= 1'b0;
            w0_data       <= '0;
            w0_hdr        <= '0;
            hi_pending    <= 1'b0;
            hi_rxd        <= {4{XGMII_IDLE}};
            hi_rxc        <= 4'hF;
            o_xgmii_rxd   <= {4{XGMII_IDLE}};
            o_xgmii_rxc   <= 4'hF;
            o_xgmii_valid <= 1'b0;
            o_decode_err  <= 1'b0;
        end else begin
            // A drop and a block result can never land on the same cycle.
            o_decode_err <= drop_w0;
            if (hdr_word) begin
                w0_pending <= 1'b1;
                w0_data    <= i_rx_data;
                w0_hdr     <= i_rx_hdr;
            end else if (accept_w1) begin
                w0_pending <= 1'b0;
            end

            // accept_w1 and hi_pending are never both set: W1 needs a W0
            // on the previous valid cycle, which cannot also be a W1.
            if (accept_w1) begin
                o_xgmii_rxd   <= lo_rxd_d;
                o_xgmii_rxc   <= lo_rxc_d;
                o_xgmii_valid <= 1'b1;
                o_decode_err  <= blk_err;
                hi_pending    <= 1'b1;
                hi_rxd        <= hi_rxd_d;
                hi_rxc        <= hi_rxc_d;
            end else if (hi_pending) begin
                o_xgmii_rxd   <= hi_rxd;
                o_xgmii_rxc   <= hi_rxc;
                o_xgmii_valid <= 1'b1;
                hi_pending    <= 1'b0;
            end else begin
                o_xgmii_valid <= 1'b0;
            end
        end
    end

`ifdef XGMII_DECODER_ERR_CNT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_err_count <= '0;
        else if (o_decode_err && o_err_count != 16'hFFFF)
            o_err_count <= o_err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_xgmii_decoder.sv
// tb/tb_xgmii_decoder.sv - directed table-driven bench for xgmii_decoder
module tb_xgmii_decoder;

    typedef struct {
        logic [1:0]  hdr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] lo_d;
        logic [3:0]  lo_c;
        logic [31:0] hi_d;
        logic [3:0]  hi_c;
        logic        err;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_rx_data;
    logic [1:0]  i_rx_hdr;
    logic        i_rx_valid;
    logic        i_rx_hdr_valid;
    logic [31:0] o_xgmii_rxd;
    logic [3:0]  o_xgmii_rxc;
    logic        o_xgmii_valid;
    logic        o_decode_err;
`ifdef XGMII_DECODER_ERR_CNT_EN
    logic [15:0] o_err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 i_clk = ~i_clk;

    xgmii_decoder dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_rx_data      (i_rx_data),
        .i_rx_hdr       (i_rx_hdr),
        .i_rx_valid     (i_rx_valid),
        .i_rx_hdr_valid (i_rx_hdr_valid),
        .o_xgmii_rxd    (o_xgmii_rxd),
        .o_xgmii_rxc    (o_xgmii_rxc),
        .o_xgmii_valid  (o_xgmii_valid),
        .o_decode_err   (o_decode_err)
`ifdef XGMII_DECODER_ERR_CNT_EN
        ,
        .o_err_count    (o_err_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name);
`ifdef XGMII_DECODER_ERR_CNT_EN
        check(name, {16'h0, o_err_count}, exp_cnt);
`endif
    endtask

    task automatic drive(input logic v, input logic hv, input logic [1:0] h, input logic [31:0] d);
        i_rx_valid     = v;
        i_rx_hdr_valid = hv;
        i_rx_hdr       = h;
        i_rx_data      = d;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 2'b11, $urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rxd"},   o_xgmii_rxd, 32'h07070707);
        check({tag, "_rxc"},   o_xgmii_rxc, 4'hF);
        check({tag, "_valid"}, o_xgmii_valid, 1'b0);
        check({tag, "_err"},   o_decode_err, 1'b0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge i_clk); drive(1'b1, 1'b1, v.hdr, v.w0);
        @(negedge i_clk); drive(1'b1, 1'b0, 2'b11, v.w1);
        @(negedge i_clk); idle_in();
        check($sformatf("v%0d_lo_rxd", idx), o_xgmii_rxd, v.lo_d);
        check($sformatf("v%0d_lo_rxc", idx), o_xgmii_rxc, v.lo_c);
        check($sformatf("v%0d_lo_valid", idx), o_xgmii_valid, 1'b1);
        check($sformatf("v%0d_lo_err", idx), o_decode_err, v.err);
        if (v.err) exp_cnt++;
        @(negedge i_clk);
        check($sformatf("v%0d_hi_rxd", idx), o_xgmii_rxd, v.hi_d);
        check($sformatf("v%0d_hi_rxc", idx), o_xgmii_rxc, v.hi_c);
        check($sformatf("v%0d_hi_valid", idx), o_xgmii_valid, 1'b1);
        check($sformatf("v%0d_hi_err", idx), o_decode_err, 1'b0);
        check_cnt($sformatf("v%0d_err_count", idx));
        @(negedge i_clk);
        check($sformatf("v%0d_after_valid", idx), o_xgmii_valid, 1'b0);
    endtask

    function automatic vec_t mkv(input logic [1:0] h, input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] lod, input logic [3:0] loc,
                                 input logic [31:0] hid, input logic [3:0] hic, input logic e);
        vec_t v;
        v.hdr = h; v.w0 = w0; v.w1 = w1;
        v.lo_d = lod; v.lo_c = loc; v.hi_d = hid; v.hi_c = hic; v.err = e;
        return v;
    endfunction

    function automatic vec_t mkerr(input logic [1:0] h, input logic [31:0] w0, input logic [31:0] w1);
        return mkv(h, w0, w1, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
    endfunction

    // 0x1E block built from eight C fields, Cn at bits [7n+14:7n+8]
    function automatic logic [63:0] cblk(input logic [6:0] c0, input logic [6:0] c1,
                                         input logic [6:0] c2, input logic [6:0] c3,
                                         input logic [6:0] c4, input logic [6:0] c5,
                                         input logic [6:0] c6, input logic [6:0] c7);
        logic [63:0] b;
        b = 64'h1E;
        b[14:8] = c0;  b[21:15] = c1; b[28:22] = c2; b[35:29] = c3;
        b[42:36] = c4; b[49:43] = c5; b[56:50] = c6; b[63:57] = c7;
        return b;
    endfunction

    vec_t        vecs [21];
    logic [63:0] b;
    logic [31:0] s_in  [6];
    logic        s_hv  [6];
    logic [1:0]  s_hdr [6];
    logic [31:0] s_rxd [6];
    logic [3:0]  s_rxc [6];

    initial begin
        vecs[0]  = mkv(2'b10, 32'h0000001E, 32'h0, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0);
        vecs[1]  = mkv(2'b10, 32'h33221178, 32'h77665544, 32'h332211FB, 4'h1, 32'h77665544, 4'h0, 1'b0);
        vecs[2]  = mkv(2'b01, 32'h03020100, 32'h07060504, 32'h03020100, 4'h0, 32'h07060504, 4'h0, 1'b0);
        vecs[3]  = mkv(2'b10, 32'hA3A2A1FF, 32'hA7A6A5A4, 32'hA4A3A2A1, 4'h0, 32'hFDA7A6A5, 4'h8, 1'b0);
        vecs[4]  = mkv(2'b10, 32'h00000033, 32'hC3B2A1F0, 32'h07070707, 4'hF, 32'hC3B2A1FB, 4'h1, 1'b0);
        vecs[5]  = mkv(2'b10, 32'h00000087, 32'h0, 32'h070707FD, 4'hF, 32'h07070707, 4'hF, 1'b0);
        vecs[6]  = mkerr(2'b00, 32'h0000001E, 32'h0);
        vecs[7]  = mkerr(2'b01, 32'h03020100, 32'h07060504);
        vecs[8]  = mkv(2'b10, 32'h0302014B, 32'h0, 32'h0302019C, 4'h1, 32'h07070707, 4'hF, 1'b0);
        vecs[9]  = mkv(2'b10, 32'h0302014B, 32'h0000000F, 32'h0302015C, 4'h1, 32'h07070707, 4'hF, 1'b0);
        vecs[10] = mkerr(2'b10, 32'h0302014B, 32'h00000005);
        b = cblk(7'h06, 7'h2D, 7'h1E, 7'h7F, 7'h33, 7'h4B, 7'h55, 7'h66);
        vecs[11] = mkv(2'b10, b[31:0], b[63:32], 32'hFEFE1C06, 4'hF, 32'hDCBC7C3C, 4'hF, 1'b0);
        b = cblk(7'h78, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h11);
        vecs[12] = mkv(2'b10, b[31:0], b[63:32], 32'h0707FEF7, 4'hF, 32'hFE070707, 4'hF, 1'b0);
        vecs[13] = mkerr(2'b10, 32'h0000002D, 32'h0);
        vecs[14] = mkerr(2'b11, 32'h0000001E, 32'h0);
        vecs[15] = mkerr(2'b10, 32'h131211CC, 32'hFFFFFF14);
        vecs[16] = vecs[1];
        vecs[17] = mkv(2'b10, 32'h131211CC, 32'hFFFFFF14, 32'h14131211, 4'h0, 32'h070707FD, 4'hF, 1'b0);
        vecs[18] = vecs[1];
        vecs[19] = mkerr(2'b10, 32'h33221178, 32'h77665544);
        vecs[20] = vecs[0];

        // Reset state
        i_reset = 1'b1;
        idle_in();
        repeat (2) @(negedge i_clk);
        check_reset_vals("reset");
        check_cnt("reset_err_count");
        i_reset = 1'b0;

        for (int i = 0; i < 21; i++) run_vec(i, vecs[i]);

        // Back-to-back start, data, terminate with valid on every cycle
        s_in  = '{32'h33221178, 32'h77665544, 32'h03020100, 32'h07060504, 32'hA3A2A1FF, 32'hA7A6A5A4};
        s_hv  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        s_hdr = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
        s_rxd = '{32'h332211FB, 32'h77665544, 32'h03020100, 32'h07060504, 32'hA4A3A2A1, 32'hFDA7A6A5};
        s_rxc = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
        for (int j = 0; j < 8; j++) begin
            @(negedge i_clk);
            if (j >= 2) begin
                check($sformatf("stream%0d_rxd", j - 2), o_xgmii_rxd, s_rxd[j-2]);
                check($sformatf("stream%0d_rxc", j - 2), o_xgmii_rxc, s_rxc[j-2]);
                check($sformatf("stream%0d_valid", j - 2), o_xgmii_valid, 1'b1);
                check($sformatf("stream%0d_err", j - 2), o_decode_err, 1'b0);
            end
            if (j < 6) drive(1'b1, s_hv[j], s_hdr[j], s_in[j]);
            else       idle_in();
        end
        @(negedge i_clk);
        check("stream_end_valid", o_xgmii_valid, 1'b0);

        // Three invalid cycles between W0 and W1; hdr_valid alone must not count
        @(negedge i_clk); drive(1'b1, 1'b1, 2'b10, 32'h0302014B);
        for (int j = 0; j < 3; j++) begin
            @(negedge i_clk); drive(1'b0, 1'b1, 2'b10, 32'hDEADBEEF);
            if (j > 0) check($sformatf("gap%0d_valid", j), o_xgmii_valid, 1'b0);
        end
        @(negedge i_clk); drive(1'b1, 1'b0, 2'b11, 32'h0);
        check("gap2_valid_end", o_xgmii_valid, 1'b0);
        @(negedge i_clk); idle_in();
        check("gap_lo_rxd", o_xgmii_rxd, 32'h0302019C);
        check("gap_lo_rxc", o_xgmii_rxc, 4'h1);
        check("gap_lo_valid", o_xgmii_valid, 1'b1);
        @(negedge i_clk);
        check("gap_hi_rxd", o_xgmii_rxd, 32'h07070707);
        check("gap_hi_rxc", o_xgmii_rxc, 4'hF);
        check("gap_hi_valid", o_xgmii_valid, 1'b1);

        // Two hdr_valid words in a row, then reset between the output halves
        @(negedge i_clk); drive(1'b1, 1'b1, 2'b10, 32'h12345678);
        @(negedge i_clk); drive(1'b1, 1'b1, 2'b10, 32'h33221178);
        check("drop_first_err", o_decode_err, 1'b0);
        @(negedge i_clk); drive(1'b1, 1'b0, 2'b11, 32'h77665544);
        check("drop_err_pulse", o_decode_err, 1'b1);
        check("drop_valid", o_xgmii_valid, 1'b0);
        exp_cnt++;
        @(negedge i_clk); idle_in();
        check("drop_lo_rxd", o_xgmii_rxd, 32'h332211FB);
        check("drop_lo_rxc", o_xgmii_rxc, 4'h1);
        check("drop_lo_err", o_decode_err, 1'b0);
        #1 i_reset = 1'b1;
        exp_cnt = 0;
        #1;
        check_reset_vals("midreset");
        check_cnt("midreset_err_count");
        @(negedge i_clk); i_reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge i_clk);
            check($sformatf("postreset%0d_valid", j), o_xgmii_valid, 1'b0);
        end

        // Reset with only W0 pending: the following W1 must be ignored
        @(negedge i_clk); drive(1'b1, 1'b1, 2'b10, 32'h0000001E);
        @(negedge i_clk); i_reset = 1'b1; idle_in();
        @(negedge i_clk); i_reset = 1'b0;
        drive(1'b1, 1'b0, 2'b11, 32'h0);
        @(negedge i_clk); idle_in();
        check("orphan_w1_valid", o_xgmii_valid, 1'b0);
        @(negedge i_clk);
        check("orphan_w1_valid2", o_xgmii_valid, 1'b0);

        // FSM back in RX_C after reset: control block decodes cleanly
        run_vec(100, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
